// File: rtl/arm_bus_pkg.sv
// Shared widths, state encodings and constants for the ARM asynchronous bus front end.
package arm_bus_pkg;

    localparam int ARM_ADDR_W  = 24;
    localparam int ARM_DATA_W  = 32;
    localparam int ARM_BE_W    = 4;
    localparam int DATA_SYNC_W = ARM_ADDR_W + ARM_DATA_W + ARM_BE_W;
    localparam int CTRL_SYNC_W = 3;

    localparam logic [ARM_DATA_W-1:0] RD_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRIVE,
        WAIT_END
    } state_e;

    typedef enum logic [1:0] {
        TXN_WR,
        TXN_RD,
        TXN_ERR
    } txn_e;

    // A collision transaction owns both strobes, so both must be released before ending it.
    function automatic logic strobe_released(input txn_e kind, input logic ws_s, input logic rs_s);
        case (kind)
            TXN_WR:  return ws_s;
            TXN_RD:  return rs_s;
            default: return ws_s & rs_s;
        endcase
    endfunction

endpackage

// File: rtl/bus_sync_chain.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs with a configurable reset value.
module bus_sync_chain #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/arm_bus_front.sv
// ARM asynchronous bus front end: synchronizes the raw bus, glitch-filters strobes and issues register-file requests.
// Optional macro ARM_BUS_DTACK_EN drives arm_dtack_b over the transfer window; without it arm_dtack_b is tied high.
module arm_bus_front
    import arm_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ARM_ADDR_W-1:0] arm_a,
    input  logic [ARM_DATA_W-1:0] arm_d_in,
    input  logic [ARM_BE_W-1:0]   arm_be_b,
    input  logic                  cs_b,
    input  logic                  ws_b,
    input  logic                  rs_b,
    output logic [ARM_ADDR_W-1:0] bus_addr,
    output logic [ARM_DATA_W-1:0] bus_wdata,
    output logic [ARM_BE_W-1:0]   bus_be,
    output logic                  bus_wr,
    output logic                  bus_rd,
    input  logic [ARM_DATA_W-1:0] bus_rdata,
    input  logic                  bus_rvalid,
    output logic [ARM_DATA_W-1:0] arm_d_out,
    output logic                  arm_d_oe,
    output logic                  arm_dtack_b,
    output logic                  err
);

    localparam int               CNT_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [2:0]       SETTLE_MAX = 3'(SYNC_STAGES);

    logic [ARM_ADDR_W-1:0]  a_s;
    logic [ARM_DATA_W-1:0]  d_s;
    logic [ARM_BE_W-1:0]    be_s;
    logic                   cs_s;
    logic                   ws_s;
    logic                   rs_s;
    logic [DATA_SYNC_W-1:0] data_s;
    logic [CTRL_SYNC_W-1:0] ctrl_s;

    bus_sync_chain #(
        .WIDTH     (DATA_SYNC_W),
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL ({DATA_SYNC_W{1'b0}})
    ) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  ({arm_a, arm_d_in, arm_be_b}),
        .d_out (data_s)
    );

    bus_sync_chain #(
        .WIDTH     (CTRL_SYNC_W),
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL ({CTRL_SYNC_W{1'b1}})
    ) u_ctrl_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  ({cs_b, ws_b, rs_b}),
        .d_out (ctrl_s)
    );

    assign {a_s, d_s, be_s}   = data_s;
    assign {cs_s, ws_s, rs_s} = ctrl_s;

    state_e                state_q,     state_d;
    txn_e                  kind_q,      kind_d;
    logic                  wr_seen_q,   wr_seen_d;
    logic                  rd_seen_q,   rd_seen_d;
    logic                  armed_q,     armed_d;
    logic [2:0]            settle_q,    settle_d;
    logic                  rd_wait_q,   rd_wait_d;
    logic [CNT_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
    logic [ARM_ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [ARM_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [ARM_BE_W-1:0]   bus_be_q,    bus_be_d;
    logic                  bus_wr_q,    bus_wr_d;
    logic                  bus_rd_q,    bus_rd_d;
    logic [ARM_DATA_W-1:0] arm_d_out_q, arm_d_out_d;
    logic                  arm_d_oe_q,  arm_d_oe_d;
    logic                  err_q,       err_d;
`ifdef ARM_BUS_DTACK_EN
    logic                  dtack_b_q,   dtack_b_d;
`endif

    // Requests are only accepted once the synchronizers hold real post-reset samples and the
    // strobes have been seen released, so a strobe held low across reset cannot start a transfer.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        wr_seen_d   = 1'b0;
        rd_seen_d   = 1'b0;
        armed_d     = armed_q;
        settle_d    = (settle_q < SETTLE_MAX) ? settle_q + 3'd1 : settle_q;
        rd_wait_d   = rd_wait_q;
        tmo_cnt_d   = tmo_cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        arm_d_out_d = arm_d_out_q;
        arm_d_oe_d  = arm_d_oe_q;
        err_d       = err_q;
`ifdef ARM_BUS_DTACK_EN
        dtack_b_d   = dtack_b_q;
`endif

        case (state_q)
            IDLE: begin
                if (settle_q == SETTLE_MAX && ws_s && rs_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    if (!ws_s && !rs_s) begin
                        err_d   = 1'b1;
                        kind_d  = TXN_ERR;
                        state_d = WAIT_END;
                    end else if (!ws_s) begin
                        wr_seen_d = 1'b1;
                        if (wr_seen_q) begin
                            bus_addr_d  = a_s;
                            bus_wdata_d = d_s;
                            bus_be_d    = ~be_s;
                            kind_d      = TXN_WR;
                            state_d     = WRITE;
                        end
                    end else if (!rs_s) begin
                        rd_seen_d = 1'b1;
                        if (rd_seen_q) begin
                            bus_addr_d = a_s;
                            bus_be_d   = ~be_s;
                            kind_d     = TXN_RD;
                            rd_wait_d  = 1'b0;
                            state_d    = READ;
                        end
                    end
                end
            end

            WRITE: begin
                bus_wr_d = 1'b1;
                state_d  = WAIT_END;
`ifdef ARM_BUS_DTACK_EN
                dtack_b_d = 1'b0;
`endif
            end

            READ: begin
                if (!rd_wait_q) begin
                    bus_rd_d  = 1'b1;
                    tmo_cnt_d = '0;
                    rd_wait_d = 1'b1;
                end else if (bus_rvalid || tmo_cnt_q == TMO_LAST) begin
                    arm_d_out_d = bus_rvalid ? bus_rdata : RD_TIMEOUT_DATA;
                    err_d       = err_q | ~bus_rvalid;
                    arm_d_oe_d  = 1'b1;
                    state_d     = DRIVE;
`ifdef ARM_BUS_DTACK_EN
                    dtack_b_d = 1'b0;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            DRIVE: begin
                state_d = WAIT_END;
            end

            WAIT_END: begin
                if (cs_s || strobe_released(kind_q, ws_s, rs_s)) begin
                    arm_d_oe_d = 1'b0;
                    state_d    = IDLE;
`ifdef ARM_BUS_DTACK_EN
                    dtack_b_d = 1'b1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= TXN_WR;
            wr_seen_q   <= 1'b0;
            rd_seen_q   <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= 3'd0;
            rd_wait_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            arm_d_out_q <= '0;
            arm_d_oe_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef ARM_BUS_DTACK_EN
            dtack_b_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            wr_seen_q   <= wr_seen_d;
            rd_seen_q   <= rd_seen_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            rd_wait_q   <= rd_wait_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_wr_q    <= bus_wr_d;
            bus_rd_q    <= bus_rd_d;
            arm_d_out_q <= arm_d_out_d;
            arm_d_oe_q  <= arm_d_oe_d;
            err_q       <= err_d;
`ifdef ARM_BUS_DTACK_EN
            dtack_b_q   <= dtack_b_d;
`endif
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign bus_wr    = bus_wr_q;
    assign bus_rd    = bus_rd_q;
    assign arm_d_out = arm_d_out_q;
    assign arm_d_oe  = arm_d_oe_q;
    assign err       = err_q;
`ifdef ARM_BUS_DTACK_EN
    assign arm_dtack_b = dtack_b_q;
`else
    assign arm_dtack_b = 1'b1;
`endif

endmodule

// File: tb/tb_arm_bus_front.sv
// Directed bench for arm_bus_front: expected output waveforms are scheduled from the bus timing rules.
// Honours ARM_BUS_DTACK_EN when predicting arm_dtack_b.
module tb_arm_bus_front;

    localparam int S = 2;
    localparam int T = 15;
    localparam int N = 512;
`ifdef ARM_BUS_DTACK_EN
    localparam bit DTACK_ACTIVE = 1'b0;
`else
    localparam bit DTACK_ACTIVE = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] arm_a;
    logic [31:0] arm_d_in;
    logic [3:0]  arm_be_b;
    logic        cs_b, ws_b, rs_b;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_wr, bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] arm_d_out;
    logic        arm_d_oe;
    logic        arm_dtack_b;
    logic        err;

    arm_bus_front #(
        .SYNC_STAGES (S),
        .RD_TIMEOUT  (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm_a       (arm_a),
        .arm_d_in    (arm_d_in),
        .arm_be_b    (arm_be_b),
        .cs_b        (cs_b),
        .ws_b        (ws_b),
        .rs_b        (rs_b),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_wr      (bus_wr),
        .bus_rd      (bus_rd),
        .bus_rdata   (bus_rdata),
        .bus_rvalid  (bus_rvalid),
        .arm_d_out   (arm_d_out),
        .arm_d_oe    (arm_d_oe),
        .arm_dtack_b (arm_dtack_b),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          exp_wr      [N];
    bit          exp_rd      [N];
    bit          exp_oe      [N];
    bit          exp_err     [N];
    bit          exp_dtack_b [N];
    logic [31:0] exp_dout    [N];
    logic [31:0] exp_wdata   [N];
    logic [23:0] exp_addr    [N];
    logic [3:0]  exp_be      [N];

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, expv);
    endtask

    task automatic applyStimulus(input logic cs, input logic ws, input logic rs,
                                 input logic [23:0] a, input logic [31:0] d, input logic [3:0] be_b);
        cs_b     = cs;
        ws_b     = ws;
        rs_b     = rs;
        arm_a    = a;
        arm_d_in = d;
        arm_be_b = be_b;
    endtask

    task automatic goToCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expectPulse(input bit is_wr, input int c, input logic [23:0] a,
                               input logic [3:0] be, input logic [31:0] d);
        if (is_wr) exp_wr[c] = 1'b1;
        else       exp_rd[c] = 1'b1;
        exp_addr[c]  = a;
        exp_be[c]    = be;
        exp_wdata[c] = d;
    endtask

    task automatic expectDtackLow(input int c0, input int c1);
        for (int k = c0; k <= c1; k++) exp_dtack_b[k] = DTACK_ACTIVE;
    endtask

    task automatic expectDrive(input int c0, input int c1, input logic [31:0] d);
        for (int k = c0; k <= c1; k++) begin
            exp_oe[k]   = 1'b1;
            exp_dout[k] = d;
        end
        expectDtackLow(c0, c1);
    endtask

    task automatic expectErrFrom(input int c, input bit v);
        for (int k = c; k < N; k++) exp_err[k] = v;
    endtask

    // Every cycle after the first reset edge, the outputs must match the scheduled waveforms.
    always @(negedge clk) begin
        if (check_en && cyc < N) begin
            checkOutput("bus_wr",      32'(bus_wr),      32'(exp_wr[cyc]));
            checkOutput("bus_rd",      32'(bus_rd),      32'(exp_rd[cyc]));
            checkOutput("arm_d_oe",    32'(arm_d_oe),    32'(exp_oe[cyc]));
            checkOutput("err",         32'(err),         32'(exp_err[cyc]));
            checkOutput("arm_dtack_b", 32'(arm_dtack_b), 32'(exp_dtack_b[cyc]));
            if (exp_oe[cyc]) checkOutput("arm_d_out", arm_d_out, exp_dout[cyc]);
            if (exp_wr[cyc] || exp_rd[cyc]) begin
                checkOutput("bus_addr", 32'(bus_addr), 32'(exp_addr[cyc]));
                checkOutput("bus_be",   32'(bus_be),   32'(exp_be[cyc]));
            end
            if (exp_wr[cyc]) checkOutput("bus_wdata", bus_wdata, exp_wdata[cyc]);
        end
    end

    initial begin
        int t;
        int r1;
        for (int k = 0; k < N; k++) exp_dtack_b[k] = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h0, 32'h0, 4'hF);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        @(posedge clk);
        #2;
        check_en = 1'b1;
        checkOutput("rst_bus_addr",  32'(bus_addr),    32'h0);
        checkOutput("rst_bus_wdata", bus_wdata,        32'h0);
        checkOutput("rst_bus_be",    32'(bus_be),      32'h0);
        checkOutput("rst_arm_d_out", arm_d_out,        32'h0);
        checkOutput("rst_arm_d_oe",  32'(arm_d_oe),    32'h0);
        checkOutput("rst_dtack_b",   32'(arm_dtack_b), 32'h1);
        goToCycle(3);
        rst = 1'b0;
        goToCycle(10);

        // Long write with a stray rvalid while waiting for the strobe release
        t = cyc;
        expectPulse(1'b1, t + S + 3, 24'h000010, 4'hF, 32'h12345678);
        expectDtackLow(t + S + 3, t + S + 20);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000010, 32'h12345678, 4'b0000);
        goToCycle(t + S + 3);
        checkOutput("wr_pulse", 32'(bus_wr),    32'h1);
        checkOutput("wr_addr",  32'(bus_addr),  32'h10);
        checkOutput("wr_data",  bus_wdata,      32'h12345678);
        checkOutput("wr_be",    32'(bus_be),    32'hF);
        goToCycle(t + 10);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h11111111;
        goToCycle(t + 11);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        goToCycle(t + 20);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000010, 32'h12345678, 4'b0000);
        goToCycle(t + 30);

        // Short write with partial byte enables
        t = cyc;
        expectPulse(1'b1, t + S + 3, 24'hABCDEF, 4'b0101, 32'hA5A55A5A);
        expectDtackLow(t + S + 3, t + S + 8);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'hABCDEF, 32'hA5A55A5A, 4'b1010);
        goToCycle(t + S + 3);
        checkOutput("wr2_be", 32'(bus_be), 32'h5);
        goToCycle(t + 8);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'hABCDEF, 32'hA5A55A5A, 4'b1010);
        goToCycle(t + 20);

        // One-cycle write glitch must be filtered
        t = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h000020, 32'h0BADBAD0, 4'b0000);
        goToCycle(t + 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000020, 32'h0BADBAD0, 4'b0000);
        goToCycle(t + 12);

        // Read answered three cycles after bus_rd
        t = cyc;
        expectPulse(1'b0, t + S + 3, 24'h000200, 4'hF, 32'h0);
        expectDrive(t + S + 7, t + S + 20, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000200, 32'h0, 4'b0000);
        goToCycle(t + S + 6);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFEF00D;
        goToCycle(t + S + 7);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        goToCycle(t + S + 8);
        checkOutput("rd_dout", arm_d_out,     32'hCAFEF00D);
        checkOutput("rd_oe",   32'(arm_d_oe), 32'h1);
        goToCycle(t + 20);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000200, 32'h0, 4'b0000);
        goToCycle(t + S + 21);
        checkOutput("rd_oe_release", 32'(arm_d_oe), 32'h0);
        goToCycle(t + 30);

        // Read that is never answered
        t = cyc;
        expectPulse(1'b0, t + S + 3, 24'h000004, 4'b0011, 32'h0);
        expectDrive(t + S + T + 3, t + S + 25, 32'hDEADBEEF);
        expectErrFrom(t + S + T + 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000004, 32'h0, 4'b1100);
        goToCycle(t + S + T + 2);
        checkOutput("tmo_not_early", 32'(arm_d_oe), 32'h0);
        goToCycle(t + S + T + 3);
        checkOutput("tmo_dout", arm_d_out, 32'hDEADBEEF);
        checkOutput("tmo_err",  32'(err),  32'h1);
        goToCycle(t + 25);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000004, 32'h0, 4'b1100);
        goToCycle(t + 40);
        checkOutput("err_sticky", 32'(err), 32'h1);

        // Plain reset clears the sticky error
        t = cyc;
        rst = 1'b1;
        expectErrFrom(t + 1, 1'b0);
        goToCycle(t + 1);
        rst = 1'b0;
        checkOutput("rst2_err",  32'(err), 32'h0);
        checkOutput("rst2_dout", arm_d_out, 32'h0);
        goToCycle(t + 12);

        // Both strobes low together
        t = cyc;
        expectErrFrom(t + S + 1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h000008, 32'h0, 4'b0000);
        goToCycle(t + S);
        checkOutput("coll_err_before", 32'(err), 32'h0);
        goToCycle(t + S + 1);
        checkOutput("coll_err", 32'(err), 32'h1);
        goToCycle(t + 5);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000008, 32'h0, 4'b0000);
        goToCycle(t + 15);

        // Reset while driving read data, strobe kept low across reset
        t = cyc;
        expectPulse(1'b0, t + S + 3, 24'h000300, 4'hF, 32'h0);
        expectDrive(t + S + 7, t + S + 7, 32'h600DD00D);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000300, 32'h0, 4'b0000);
        goToCycle(t + S + 6);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h600DD00D;
        goToCycle(t + S + 7);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        rst = 1'b1;
        expectErrFrom(t + S + 8, 1'b0);
        goToCycle(t + S + 8);
        rst = 1'b0;
        checkOutput("drv_rst_oe",    32'(arm_d_oe),    32'h0);
        checkOutput("drv_rst_err",   32'(err),         32'h0);
        checkOutput("drv_rst_dtack", 32'(arm_dtack_b), 32'h1);
        goToCycle(t + S + 30);
        r1 = cyc;
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000300, 32'h0, 4'b0000);
        goToCycle(r1 + 10);
        t = cyc;
        expectPulse(1'b0, t + S + 3, 24'h000300, 4'hF, 32'h0);
        expectDrive(t + S + 7, t + S + 20, 32'h13579BDF);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000300, 32'h0, 4'b0000);
        goToCycle(t + S + 3);
        checkOutput("rearm_rd", 32'(bus_rd), 32'h1);
        goToCycle(t + S + 6);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h13579BDF;
        goToCycle(t + S + 7);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        goToCycle(t + 20);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000300, 32'h0, 4'b0000);
        goToCycle(t + 35);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
